// File: rtl/duck_sprite_renderer.sv
// Single-sprite raster renderer: maps DrawX/DrawY to a sprite ROM address, then
// resolves palette colour through a 3-stage pipeline with a transparent colour key.
module duck_sprite_renderer #(
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 64,
  parameter int NUM_FRAMES  = 4,
  parameter int IDX_W       = 4,
  parameter int TRANSPARENT = 0,
  parameter int ANIM_DIV    = 8,
  parameter int ADDR_W      = $clog2(SPR_W*SPR_H*NUM_FRAMES)
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_tick,
  input  logic signed [10:0] pos_x,
  input  logic signed [10:0] pos_y,
  input  logic [1:0]         scale_log2,
  input  logic               flip_h,
  input  logic               anim_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               sprite_on
);

  localparam int LX_W  = $clog2(SPR_W);
  localparam int LY_W  = $clog2(SPR_H);
  localparam int FR_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int CAT_W = FR_W + LY_W + LX_W;

  // Animation state
  logic [FR_W-1:0]  frame_idx_q, frame_idx_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  // Pipeline registers
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]        hit_pipe_q, blank_pipe_q;
  logic [3:0]        red_q, green_q, blue_q, red_d, green_d, blue_d;
  logic              sprite_on_q, sprite_on_d;

  // Address generation
  logic signed [11:0] dx, dy, span_x, span_y;
  logic               hit;
  logic [LX_W-1:0]    lx_raw, lx;
  logic [LY_W-1:0]    ly;
  logic [CAT_W-1:0]   addr_cat;

  // 12-bit signed offsets cannot overflow: |DrawX - pos_x| < 2048.
  assign dx     = $signed({2'b00, DrawX}) - $signed({pos_x[10], pos_x});
  assign dy     = $signed({2'b00, DrawY}) - $signed({pos_y[10], pos_y});
  assign span_x = $signed(12'(SPR_W) << scale_log2);
  assign span_y = $signed(12'(SPR_H) << scale_log2);
  assign hit    = !dx[11] && (dx < span_x) && !dy[11] && (dy < span_y);

  assign lx_raw = LX_W'($unsigned(dx) >> scale_log2);
  assign ly     = LY_W'($unsigned(dy) >> scale_log2);
  // SPR_W is a power of two, so SPR_W-1-lx is a bitwise inversion.
  assign lx     = flip_h ? ~lx_raw : lx_raw;

  assign addr_cat   = {frame_idx_q, ly, lx};
  assign rom_addr_d = hit ? ADDR_W'(addr_cat) : '0;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    frame_idx_d = frame_idx_q;
    if (frame_tick && anim_en) begin
      if (div_cnt_q == DIV_W'(ANIM_DIV-1)) begin
        div_cnt_d   = '0;
        frame_idx_d = (frame_idx_q == FR_W'(NUM_FRAMES-1)) ? '0 : frame_idx_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // Stage 3 sees rom_q for the pixel that was in stage 1 two cycles ago.
  assign pal_index = rom_q;

  always_comb begin
    sprite_on_d = hit_pipe_q[1] && blank_pipe_q[1] && (rom_q != IDX_W'(TRANSPARENT));
    red_d       = sprite_on_d ? pal_red   : 4'h0;
    green_d     = sprite_on_d ? pal_green : 4'h0;
    blue_d      = sprite_on_d ? pal_blue  : 4'h0;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_idx_q  <= '0;
      div_cnt_q    <= '0;
      rom_addr_q   <= '0;
      hit_pipe_q   <= '0;
      blank_pipe_q <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      sprite_on_q  <= 1'b0;
    end else begin
      frame_idx_q  <= frame_idx_d;
      div_cnt_q    <= div_cnt_d;
      rom_addr_q   <= rom_addr_d;
      hit_pipe_q   <= {hit_pipe_q[0], hit};
      blank_pipe_q <= {blank_pipe_q[0], blank};
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      sprite_on_q  <= sprite_on_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign sprite_on = sprite_on_q;

endmodule

// File: tb/tb_duck_sprite_renderer.sv
// Directed bench for duck_sprite_renderer: vector table for address/hit/colour,
// plus sequences for animation stepping and mid-line reset.
module tb_duck_sprite_renderer;

  logic               vga_clk = 1'b0;
  logic               reset;
  logic [9:0]         DrawX, DrawY;
  logic               blank, frame_tick, flip_h, anim_en;
  logic signed [10:0] pos_x, pos_y;
  logic [1:0]         scale_log2;
  logic [13:0]        rom_addr;
  logic [3:0]         rom_q, pal_index, pal_red, pal_green, pal_blue;
  logic [3:0]         red, green, blue;
  logic               sprite_on;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 vga_clk = ~vga_clk;

  duck_sprite_renderer #(
    .SPR_W(64), .SPR_H(64), .NUM_FRAMES(4), .IDX_W(4),
    .TRANSPARENT(0), .ANIM_DIV(2)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
    .scale_log2(scale_log2), .flip_h(flip_h), .anim_en(anim_en),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .sprite_on(sprite_on)
  );

  // Sprite ROM contents: index = (7*addr + 3) mod 16 (addr 11 is transparent).
  function automatic logic [3:0] rom_val(input logic [13:0] a);
    logic [31:0] t;
    t = 32'(a) * 7 + 3;
    return t[3:0];
  endfunction

  function automatic logic [11:0] exp_rgb(input logic [3:0] idx, input logic on);
    return on ? {idx, ~idx, idx ^ 4'h5} : 12'h000;
  endfunction

  always @(posedge vga_clk) rom_q <= rom_val(rom_addr);
  assign pal_red   = pal_index;
  assign pal_green = ~pal_index;
  assign pal_blue  = pal_index ^ 4'h5;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]         x, y;
    logic               blk;
    logic signed [10:0] px, py;
    logic [1:0]         sc;
    logic               fl;
    logic [13:0]        addr;
    logic               on;
    logic [3:0]         idx;
  } vec_t;

  vec_t vecs[14];
  int   anim_exp[8];

  initial begin
    vecs[0]  = '{10'd100, 10'd50,  1'b1, 11'sd100, 11'sd50,  2'd0, 1'b0, 14'd0,    1'b1, 4'd3};
    vecs[1]  = '{10'd100, 10'd51,  1'b1, 11'sd100, 11'sd50,  2'd0, 1'b1, 14'd127,  1'b1, 4'd12};
    vecs[2]  = '{10'd164, 10'd51,  1'b1, 11'sd100, 11'sd50,  2'd0, 1'b1, 14'd0,    1'b0, 4'd0};
    vecs[3]  = '{10'd255, 10'd7,   1'b1, 11'sd0,   11'sd0,   2'd2, 1'b0, 14'd127,  1'b1, 4'd12};
    vecs[4]  = '{10'd256, 10'd7,   1'b1, 11'sd0,   11'sd0,   2'd2, 1'b0, 14'd0,    1'b0, 4'd0};
    vecs[5]  = '{10'd0,   10'd20,  1'b1, -11'sd10, 11'sd20,  2'd0, 1'b0, 14'd10,   1'b1, 4'd9};
    vecs[6]  = '{10'd1,   10'd20,  1'b1, -11'sd10, 11'sd20,  2'd0, 1'b0, 14'd11,   1'b0, 4'd0};
    vecs[7]  = '{10'd100, 10'd50,  1'b0, 11'sd100, 11'sd50,  2'd0, 1'b0, 14'd0,    1'b0, 4'd0};
    vecs[8]  = '{10'd327, 10'd227, 1'b1, 11'sd200, 11'sd100, 2'd1, 1'b0, 14'd4095, 1'b1, 4'd12};
    vecs[9]  = '{10'd328, 10'd227, 1'b1, 11'sd200, 11'sd100, 2'd1, 1'b0, 14'd0,    1'b0, 4'd0};
    vecs[10] = '{10'd3,   10'd0,   1'b1, 11'sd0,   -11'sd5,  2'd0, 1'b0, 14'd323,  1'b1, 4'd8};
    vecs[11] = '{10'd0,   10'd9,   1'b1, 11'sd0,   11'sd10,  2'd0, 1'b0, 14'd0,    1'b0, 4'd0};
    vecs[12] = '{10'd511, 10'd511, 1'b1, 11'sd0,   11'sd0,   2'd3, 1'b1, 14'd4032, 1'b1, 4'd3};
    vecs[13] = '{10'd163, 10'd50,  1'b1, 11'sd100, 11'sd50,  2'd0, 1'b1, 14'd0,    1'b1, 4'd3};
    anim_exp = '{0, 1, 1, 2, 2, 3, 3, 0};

    // Reset, with frame_tick pulsing to confirm reset wins.
    reset = 1'b1; frame_tick = 1'b1; anim_en = 1'b1;
    DrawX = '0; DrawY = '0; blank = 1'b0; pos_x = '0; pos_y = '0;
    scale_log2 = '0; flip_h = 1'b0;
    repeat (3) step();
    chk("reset_addr", 32'(rom_addr), 32'd0);
    chk("reset_on",   32'(sprite_on), 32'd0);
    chk("reset_rgb",  32'({red, green, blue}), 32'd0);
    frame_tick = 1'b0; anim_en = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      DrawX = vecs[i].x; DrawY = vecs[i].y; blank = vecs[i].blk;
      pos_x = vecs[i].px; pos_y = vecs[i].py;
      scale_log2 = vecs[i].sc; flip_h = vecs[i].fl;
      step();
      chk($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      step(); step();
      chk($sformatf("vec%0d_on", i), 32'(sprite_on), 32'(vecs[i].on));
      chk($sformatf("vec%0d_rgb", i), 32'({red, green, blue}),
          32'(exp_rgb(vecs[i].idx, vecs[i].on)));
    end

    // Animation: ANIM_DIV=2, observe frame via rom_addr at local (0,0).
    DrawX = '0; DrawY = '0; blank = 1'b1; pos_x = '0; pos_y = '0;
    scale_log2 = '0; flip_h = 1'b0; anim_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
      chk($sformatf("anim%0d_addr", k), 32'(rom_addr), 32'(anim_exp[k] * 4096));
    end
    repeat (4) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
    chk("anim_frame2", 32'(rom_addr), 32'd8192);
    // frame_tick coincident with anim_en low: counter holds.
    anim_en = 1'b0; frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();
    chk("anim_hold", 32'(rom_addr), 32'd8192);
    step(); step();
    chk("pre_rst_on",  32'(sprite_on), 32'd1);
    chk("pre_rst_rgb", 32'({red, green, blue}), 32'(exp_rgb(rom_val(14'd8192), 1'b1)));

    // Mid-line reset at frame 2.
    reset = 1'b1; anim_en = 1'b1; frame_tick = 1'b1; step();
    frame_tick = 1'b0; anim_en = 1'b0;
    chk("mrst_addr", 32'(rom_addr), 32'd0);
    chk("mrst_on",   32'(sprite_on), 32'd0);
    chk("mrst_rgb",  32'({red, green, blue}), 32'd0);
    reset = 1'b0;
    step();
    chk("refill1_addr", 32'(rom_addr), 32'd0);
    chk("refill1_on",   32'(sprite_on), 32'd0);
    step();
    chk("refill2_on",   32'(sprite_on), 32'd0);
    step();
    chk("refill3_on",   32'(sprite_on), 32'd1);
    chk("refill3_rgb",  32'({red, green, blue}), 32'(exp_rgb(rom_val(14'd0), 1'b1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
